// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer for the 8-bit RISC core.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB. It drives the
// datapath enables and the shared memory port (req/ack). A memory access that
// gets no ack within MEM_TIMEOUT cycles sends the FSM into ERR until reset.
module multicycle_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int TW          = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [3:0] opcode,
    input  logic       zero,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_sel,
    output logic       mem_we,
    output logic       ir_load,
    output logic       pc_inc,
    output logic       pc_load,
    output logic [2:0] alu_control,
    output logic       alu_src,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       instr_done,
    output logic       bus_err,
    output logic [2:0] state
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;
    localparam logic [2:0] S_ERR    = 3'd7;

    // Instruction classes; they choose the path taken after DECODE.
    localparam logic [2:0] C_NOP    = 3'd0;
    localparam logic [2:0] C_HALT   = 3'd1;
    localparam logic [2:0] C_ALU    = 3'd2;
    localparam logic [2:0] C_LOAD   = 3'd3;
    localparam logic [2:0] C_STORE  = 3'd4;
    localparam logic [2:0] C_BRANCH = 3'd5;

    // Last access cycle that may still accept an ack. The counter holds N-1
    // on access cycle N.
    localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TIMEOUT - 1);

    logic [2:0]    state_q, state_d;
    logic [3:0]    op_q, op_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          bus_err_q, bus_err_d;

    logic [2:0]    dec_cls;
    logic [2:0]    dec_alu;
    logic          dec_src;
    logic          dec_dst;
    logic          dec_m2r;
    logic [2:0]    next_instr;
    logic          tmo_hit;

    function automatic logic [2:0] op_class(input logic [3:0] op);
        logic [2:0] cls;
        case (op)
            4'h0, 4'hE:                cls = C_NOP;
            4'hF:                      cls = C_HALT;
            4'h9, 4'hB:                cls = C_LOAD;
            4'hA, 4'hC:                cls = C_STORE;
            4'hD:                      cls = C_BRANCH;
            default:                   cls = C_ALU;
        endcase
        return cls;
    endfunction

    // Datapath controls decoded from the latched opcode.
    always_comb begin
        dec_cls = op_class(op_q);
        dec_alu = 3'b000;
        dec_src = 1'b1;
        dec_dst = 1'b0;
        dec_m2r = 1'b0;
        case (op_q)
            4'h1: begin dec_alu = 3'b000; dec_src = 1'b0; dec_dst = 1'b1; end
            4'h2: begin dec_alu = 3'b001; dec_src = 1'b0; dec_dst = 1'b1; end
            4'h3: begin dec_alu = 3'b010; dec_src = 1'b0; dec_dst = 1'b1; end
            4'h4: begin dec_alu = 3'b011; dec_src = 1'b0; dec_dst = 1'b1; end
            4'h5: dec_alu = 3'b100;
            4'h6: dec_alu = 3'b101;
            4'h8: dec_alu = 3'b001;
            4'h9, 4'hB: dec_m2r = 1'b1;
            4'hD: begin dec_alu = 3'b001; dec_src = 1'b0; end
            default: dec_alu = 3'b000;
        endcase
    end

    assign next_instr = run ? S_FETCH : S_IDLE;
    assign tmo_hit    = !mem_ack && (tmo_q == TMO_LAST);
    assign state      = state_q;
    assign bus_err    = bus_err_q;

    // Next-state, timeout counting and output decode for every state.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        tmo_d       = '0;
        mem_req     = 1'b0;
        mem_sel     = 1'b0;
        mem_we      = 1'b0;
        ir_load     = 1'b0;
        pc_inc      = 1'b0;
        pc_load     = 1'b0;
        alu_control = 3'b000;
        alu_src     = 1'b0;
        reg_dst     = 1'b0;
        reg_write   = 1'b0;
        mem_to_reg  = 1'b0;
        instr_done  = 1'b0;

        // Decoded controls stay stable for the whole execute half.
        if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
            alu_control = dec_alu;
            alu_src     = dec_src;
            reg_dst     = dec_dst;
            mem_to_reg  = dec_m2r;
        end

        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_load = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = S_DECODE;
                end else if (tmo_hit) begin
                    state_d = S_ERR;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_DECODE: begin
                op_d = opcode;
                case (op_class(opcode))
                    C_NOP: begin
                        instr_done = 1'b1;
                        state_d    = next_instr;
                    end
                    C_HALT:  state_d = S_HALT;
                    default: state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                case (dec_cls)
                    C_BRANCH: begin
                        pc_load    = zero;
                        instr_done = 1'b1;
                        state_d    = next_instr;
                    end
                    C_LOAD, C_STORE: state_d = S_MEM;
                    default:         state_d = S_WB;
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_sel = 1'b1;
                mem_we  = (dec_cls == C_STORE);
                if (mem_ack) begin
                    if (dec_cls == C_STORE) begin
                        instr_done = 1'b1;
                        state_d    = next_instr;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (tmo_hit) begin
                    state_d = S_ERR;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = next_instr;
            end
            S_HALT:  state_d = S_HALT;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase

        bus_err_d = bus_err_q | (state_d == S_ERR);
    end

    // State registers; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= 4'h0;
            tmo_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            tmo_q     <= tmo_d;
            bus_err_q <= bus_err_d;
        end
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Testbench for multicycle_sequencer. A per-instruction reference model
// expands each instruction into its expected cycle-by-cycle trace (phases,
// decode table, handshake and timeout rules). The bench then replays that
// trace against the DUT.
module tb_multicycle_sequencer;

    localparam int TO = 15;

    localparam int K_NOP = 0, K_HALT = 1, K_ALU = 2, K_LOAD = 3, K_STORE = 4, K_BR = 5;

    typedef struct packed {
        logic [2:0] st;
        logic       req, sel, we, irl, pci, pcl;
        logic [2:0] alu;
        logic       src, dst, rw, m2r, done, err;
    } obs_t;

    typedef struct packed {
        obs_t o;
        logic ack;
    } step_t;

    logic       clk = 1'b0;
    logic       rst, run, zero, mem_ack;
    logic [3:0] opcode;
    logic       mem_req, mem_sel, mem_we, ir_load, pc_inc, pc_load;
    logic [2:0] alu_control;
    logic       alu_src, reg_dst, reg_write, mem_to_reg, instr_done, bus_err;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;
    step_t exp_q[$];

    multicycle_sequencer #(.MEM_TIMEOUT(TO), .TW(4)) dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode), .zero(zero),
        .mem_ack(mem_ack), .mem_req(mem_req), .mem_sel(mem_sel),
        .mem_we(mem_we), .ir_load(ir_load), .pc_inc(pc_inc),
        .pc_load(pc_load), .alu_control(alu_control), .alu_src(alu_src),
        .reg_dst(reg_dst), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .instr_done(instr_done), .bus_err(bus_err), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic obs_t observe();
        obs_t o;
        o = {state, mem_req, mem_sel, mem_we, ir_load, pc_inc, pc_load,
             alu_control, alu_src, reg_dst, reg_write, mem_to_reg,
             instr_done, bus_err};
        return o;
    endfunction

    function automatic logic rbit();
        return logic'($urandom_range(0, 1));
    endfunction

    // Decode table of the instruction set.
    task automatic ref_decode(input logic [3:0] op, output int cls, output logic [2:0] alu,
                              output logic src, output logic dst, output logic m2r);
        alu = 3'b000; src = 1'b1; dst = 1'b0; m2r = 1'b0; cls = K_ALU;
        case (op)
            4'h0, 4'hE: cls = K_NOP;
            4'hF:       cls = K_HALT;
            4'h1: begin alu = 3'b000; src = 1'b0; dst = 1'b1; end
            4'h2: begin alu = 3'b001; src = 1'b0; dst = 1'b1; end
            4'h3: begin alu = 3'b010; src = 1'b0; dst = 1'b1; end
            4'h4: begin alu = 3'b011; src = 1'b0; dst = 1'b1; end
            4'h5: alu = 3'b100;
            4'h6: alu = 3'b101;
            4'h7: alu = 3'b000;
            4'h8: alu = 3'b001;
            4'h9, 4'hB: begin cls = K_LOAD; m2r = 1'b1; end
            4'hA, 4'hC: cls = K_STORE;
            default: begin cls = K_BR; alu = 3'b001; src = 1'b0; end
        endcase
    endtask

    task automatic push(input obs_t o, input logic ack);
        step_t s;
        s.o = o;
        s.ack = ack;
        exp_q.push_back(s);
    endtask

    task automatic push_err_tail();
        obs_t o;
        for (int i = 0; i < 3; i++) begin
            o = '0; o.st = 3'd7; o.err = 1'b1;
            push(o, rbit());
        end
    endtask

    // Replays exp_q one cycle per entry; entered just after a rising edge.
    task automatic play(input string name);
        obs_t got;
        for (int i = 0; i < exp_q.size(); i++) begin
            mem_ack = exp_q[i].ack;
            @(negedge clk);
            got = observe();
            checks++;
            if (got !== exp_q[i].o) begin
                errors++;
                $display("FAIL %s cycle %0d: got %h expected %h", name, i + 1, got, exp_q[i].o);
            end
            @(posedge clk); #1;
        end
    endtask

    // One instruction, starting in its first FETCH cycle. fdly/mdly are the
    // wait cycles before ack; TO or more means the ack never comes.
    task automatic exec_instr(input logic [3:0] op, input logic z, input int fdly, input int mdly,
                              input logic run_next, input string name, output logic [2:0] end_st);
        int cls, n;
        logic [2:0] alu;
        logic src, dst, m2r;
        obs_t o, ctl;
        ref_decode(op, cls, alu, src, dst, m2r);
        exp_q.delete();
        opcode = op; zero = z; run = run_next;
        end_st = run_next ? 3'd1 : 3'd0;
        n = (fdly >= TO) ? TO : fdly + 1;
        for (int i = 0; i < n; i++) begin
            o = '0; o.st = 3'd1; o.req = 1'b1;
            if (i == fdly) begin o.irl = 1'b1; o.pci = 1'b1; end
            push(o, i == fdly);
        end
        if (fdly >= TO) begin
            push_err_tail();
            end_st = 3'd7;
        end else begin
            o = '0; o.st = 3'd2; o.done = (cls == K_NOP);
            push(o, rbit());
            if (cls == K_HALT) begin
                for (int i = 0; i < 20; i++) begin
                    o = '0; o.st = 3'd6;
                    push(o, rbit());
                end
                end_st = 3'd6;
            end else if (cls != K_NOP) begin
                ctl = '0; ctl.alu = alu; ctl.src = src; ctl.dst = dst; ctl.m2r = m2r;
                o = ctl; o.st = 3'd3;
                if (cls == K_BR) begin o.pcl = z; o.done = 1'b1; end
                push(o, rbit());
                if (cls == K_LOAD || cls == K_STORE) begin
                    n = (mdly >= TO) ? TO : mdly + 1;
                    for (int i = 0; i < n; i++) begin
                        o = ctl; o.st = 3'd4; o.req = 1'b1; o.sel = 1'b1;
                        o.we = (cls == K_STORE);
                        o.done = (cls == K_STORE) && (i == mdly);
                        push(o, i == mdly);
                    end
                end
                if (mdly >= TO && (cls == K_LOAD || cls == K_STORE)) begin
                    push_err_tail();
                    end_st = 3'd7;
                end else if (cls == K_ALU || cls == K_LOAD) begin
                    o = ctl; o.st = 3'd5; o.rw = 1'b1; o.done = 1'b1;
                    push(o, rbit());
                end
            end
        end
        play(name);
    endtask

    // Synchronous reset for one edge, then leave IDLE with run high.
    task automatic do_reset(input string name);
        obs_t got;
        rst = 1'b1; run = 1'b1; mem_ack = rbit();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        got = observe();
        checks++;
        if (got !== obs_t'(0)) begin
            errors++;
            $display("FAIL %s_reset: got %h expected %h", name, got, obs_t'(0));
        end
        @(posedge clk); #1;
    endtask

    // Brings the DUT from the state an instruction left it in to FETCH.
    task automatic go_fetch(input logic [2:0] st, input string name);
        obs_t got;
        if (st == 3'd0) begin
            run = 1'b1; mem_ack = rbit();
            @(negedge clk);
            got = observe();
            checks++;
            if (got !== obs_t'(0)) begin
                errors++;
                $display("FAIL %s_idle: got %h expected %h", name, got, obs_t'(0));
            end
            @(posedge clk); #1;
        end else if (st != 3'd1) begin
            do_reset(name);
        end
    endtask

    task automatic test_reset();
        obs_t got;
        rst = 1'b1; run = 1'b1; mem_ack = 1'b1; opcode = 4'h1; zero = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        got = observe();
        checks++;
        if (got !== obs_t'(0)) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", got, obs_t'(0));
        end
        @(posedge clk); #1;
        rst = 1'b0; run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) run = 1'b1;
            mem_ack = rbit();
            @(negedge clk);
            got = observe();
            checks++;
            if (got !== obs_t'(0)) begin
                errors++;
                $display("FAIL idle_hold: got %h expected %h", got, obs_t'(0));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_directed();
        logic [2:0] e;
        exec_instr(4'h1, 1'b0, 0, 0, 1'b1, "add", e);        go_fetch(e, "add");
        exec_instr(4'h9, 1'b0, 0, 3, 1'b1, "ld_wait3", e);   go_fetch(e, "ld_wait3");
        exec_instr(4'hD, 1'b1, 0, 0, 1'b1, "bz_taken", e);   go_fetch(e, "bz_taken");
        exec_instr(4'hD, 1'b0, 0, 0, 1'b1, "bz_not", e);     go_fetch(e, "bz_not");
        exec_instr(4'hC, 1'b0, 0, 2, 1'b0, "sti_run0", e);   go_fetch(e, "sti_run0");
        exec_instr(4'h0, 1'b0, 1, 0, 1'b1, "nop", e);        go_fetch(e, "nop");
        exec_instr(4'h5, 1'b0, 0, 0, 1'b1, "shl", e);        go_fetch(e, "shl");
    endtask

    task automatic test_timeout();
        logic [2:0] e;
        exec_instr(4'h2, 1'b0, TO - 1, 0, 1'b1, "fetch_ack_last", e); go_fetch(e, "fetch_ack_last");
        exec_instr(4'hB, 1'b0, 0, TO - 1, 1'b1, "mem_ack_last", e);   go_fetch(e, "mem_ack_last");
        exec_instr(4'h1, 1'b0, TO, 0, 1'b1, "fetch_timeout", e);      go_fetch(e, "fetch_timeout");
        exec_instr(4'hA, 1'b0, 0, TO, 1'b1, "mem_timeout", e);        go_fetch(e, "mem_timeout");
    endtask

    task automatic test_halt();
        logic [2:0] e;
        exec_instr(4'hF, 1'b0, 0, 0, 1'b1, "halt", e);
        go_fetch(e, "halt");
    endtask

    // Reset on the second cycle of a stalled fetch gives IDLE on the next cycle.
    task automatic test_reset_mid_fetch();
        obs_t exp_o, got;
        opcode = 4'h3; run = 1'b1; mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rst = (i == 1);
            exp_o = '0;
            if (i < 2) begin exp_o.st = 3'd1; exp_o.req = 1'b1; end
            @(negedge clk);
            got = observe();
            checks++;
            if (got !== exp_o) begin
                errors++;
                $display("FAIL reset_mid_fetch cycle %0d: got %h expected %h", i + 1, got, exp_o);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] e;
        logic [3:0] op;
        int fd, md, r;
        for (int k = 0; k < 60; k++) begin
            op = 4'($urandom_range(0, 15));
            r = $urandom_range(0, 19);
            fd = (r < 16) ? r % 4 : (r < 19 ? TO - 1 : TO);
            r = $urandom_range(0, 19);
            md = (r < 16) ? r % 5 : (r < 19 ? TO - 1 : TO);
            exec_instr(op, rbit(), fd, md, rbit(), $sformatf("rand%0d_op%h", k, op), e);
            go_fetch(e, $sformatf("rand%0d", k));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_timeout();
        test_halt();
        test_reset_mid_fetch();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
